// File: rtl/ps2_pkg.sv
// Shared constants, frame state encoding and helpers for the PS/2 scan-code receiver.
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  localparam int PS2_FILT_LEN_DEF    = 8;
  localparam int PS2_TIMEOUT_CYC_DEF = 100000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_t;

  // Odd parity: data byte plus parity bit must hold an odd number of ones.
  function automatic logic parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Synchronizes raw PS/2 clock/data, debounces the clock and flags its falling edges.
module ps2_sync_filter
  import ps2_pkg::*;
#(
  parameter int FILT_LEN = PS2_FILT_LEN_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_sync,
  output logic clk_fall
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN + 1) : 1;

  logic [1:0]    clk_sync_reg;
  logic [1:0]    data_sync_reg;
  logic [CW-1:0] filt_cnt_reg;
  logic          filt_level_reg;
  logic          fall_reg;

  // Two-flop synchronizers; both lines idle high on the PS/2 bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_reg  <= 2'b11;
      data_sync_reg <= 2'b11;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[0], ps2_clk};
      data_sync_reg <= {data_sync_reg[0], ps2_data};
    end
  end

  // Accept a new clock level only after FILT_LEN consecutive differing samples;
  // a 1->0 acceptance produces a one-cycle fall pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_cnt_reg   <= '0;
      filt_level_reg <= 1'b1;
      fall_reg       <= 1'b0;
    end else if (clk_sync_reg[1] == filt_level_reg) begin
      filt_cnt_reg <= '0;
      fall_reg     <= 1'b0;
    end else if (filt_cnt_reg == CW'(FILT_LEN - 1)) begin
      filt_cnt_reg   <= '0;
      filt_level_reg <= clk_sync_reg[1];
      fall_reg       <= ~clk_sync_reg[1];
    end else begin
      filt_cnt_reg <= filt_cnt_reg + 1'b1;
      fall_reg     <= 1'b0;
    end
  end

  assign data_sync = data_sync_reg[1];
  assign clk_fall  = fall_reg;

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: frames 11-bit words, checks parity/stop/timeout and
// folds E0/F0 prefixes into a {ext, byte} key code with a break flag.
module ps2_scan_rx
  import ps2_pkg::*;
#(
  parameter int FILT_LEN    = PS2_FILT_LEN_DEF,
  parameter int TIMEOUT_CYC = PS2_TIMEOUT_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [8:0] key_code,
  output logic       key_break,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic data_sync;
  logic clk_fall;

  ps2_sync_filter #(.FILT_LEN(FILT_LEN)) u_sync_filter (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .data_sync (data_sync),
    .clk_fall  (clk_fall)
  );

  frame_state_t state_reg, state_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]    shift_reg, shift_next;
  logic          par_reg, par_next;
  logic [TW-1:0] to_cnt_reg, to_cnt_next;
  logic          ext_reg, ext_next;
  logic          brk_reg, brk_next;
  logic [8:0]    key_code_reg, key_code_next;
  logic          key_break_reg, key_break_next;
  logic          key_valid_reg, key_valid_next;
  logic          frame_err_reg, frame_err_next;

  // State and output registers; reset drops any partial frame silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      par_reg       <= 1'b0;
      to_cnt_reg    <= '0;
      ext_reg       <= 1'b0;
      brk_reg       <= 1'b0;
      key_code_reg  <= 9'h000;
      key_break_reg <= 1'b0;
      key_valid_reg <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      par_reg       <= par_next;
      to_cnt_reg    <= to_cnt_next;
      ext_reg       <= ext_next;
      brk_reg       <= brk_next;
      key_code_reg  <= key_code_next;
      key_break_reg <= key_break_next;
      key_valid_reg <= key_valid_next;
      frame_err_reg <= frame_err_next;
    end
  end

  // Frame FSM, prefix decode and timeout supervision.
  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    par_next       = par_reg;
    ext_next       = ext_reg;
    brk_next       = brk_reg;
    key_code_next  = key_code_reg;
    key_break_next = key_break_reg;
    key_valid_next = 1'b0;
    frame_err_next = 1'b0;
    to_cnt_next    = (state_reg == IDLE || clk_fall) ? '0 : to_cnt_reg + 1'b1;

    case (state_reg)
      IDLE: begin
        if (clk_fall && !data_sync) begin
          state_next   = DATA;
          bit_cnt_next = '0;
        end
      end
      DATA: begin
        if (clk_fall) begin
          shift_next   = {data_sync, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == 3'd7) state_next = PARITY;
        end
      end
      PARITY: begin
        if (clk_fall) begin
          par_next   = data_sync;
          state_next = STOP;
        end
      end
      STOP: begin
        if (clk_fall) begin
          state_next = IDLE;
          if (parity_ok(shift_reg, par_reg) && data_sync) begin
            if (shift_reg == PS2_PREFIX_EXT) begin
              ext_next = 1'b1;
            end else if (shift_reg == PS2_PREFIX_BRK) begin
              brk_next = 1'b1;
            end else begin
              key_code_next  = {ext_reg, shift_reg};
              key_break_next = brk_reg;
              key_valid_next = 1'b1;
              ext_next       = 1'b0;
              brk_next       = 1'b0;
            end
          end else begin
            frame_err_next = 1'b1;
            ext_next       = 1'b0;
            brk_next       = 1'b0;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // A stalled frame is abandoned; a fresh edge always restarts the count.
    if (state_reg != IDLE && !clk_fall && to_cnt_reg == TW'(TIMEOUT_CYC - 1)) begin
      state_next     = IDLE;
      to_cnt_next    = '0;
      frame_err_next = 1'b1;
      ext_next       = 1'b0;
      brk_next       = 1'b0;
    end
  end

  assign key_code  = key_code_reg;
  assign key_break = key_break_reg;
  assign key_valid = key_valid_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Directed bench for ps2_scan_rx: drives PS/2 frames bit by bit and checks
// decoded keys, error pulses, timeout timing and reset behaviour.
module tb_ps2_scan_rx;

  localparam int FILT  = 4;
  localparam int TOUT  = 200;
  localparam int HALF  = 20;   // clk cycles per PS/2 clock phase
  localparam int GAP   = 40;

  logic       clk;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [8:0] key_code;
  logic       key_break;
  logic       key_valid;
  logic       frame_err;

  ps2_scan_rx #(.FILT_LEN(FILT), .TIMEOUT_CYC(TOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .key_code  (key_code),
    .key_break (key_break),
    .key_valid (key_valid),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_err = 0;
  int overlap = 0;
  int consec = 0;
  int cyc = 0;
  int err_cyc = 0;
  int fall_cyc = 0;
  logic prev_v = 1'b0;
  logic prev_e = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts events and flags overlapping or stretched pulses.
  always @(negedge clk) begin
    prev_v <= key_valid;
    prev_e <= frame_err;
    if (key_valid) n_valid <= n_valid + 1;
    if (frame_err) begin
      n_err   <= n_err + 1;
      err_cyc <= cyc;
    end
    if (key_valid && frame_err) overlap <= overlap + 1;
    if ((key_valid && prev_v) || (frame_err && prev_e)) consec <= consec + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (HALF / 2) @(negedge clk);
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF / 2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
    logic p;
    p = ~(^b) ^ bad_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(p);
    send_bit(stop);
    ps2_data = 1'b1;
    repeat (GAP) @(negedge clk);
    $display("frame %02h par_flip=%0b stop=%0b -> valid=%0d err=%0d code=%03h brk=%0b",
             b, bad_par, stop, n_valid, n_err, key_code, key_break);
  endtask

  int v0, e0;
  logic [7:0] b29;
  logic [7:0] b74;

  initial begin
    rst_n = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_code", 32'(key_code), 32'h000);
    check("rst_break", 32'(key_break), 0);
    check("rst_valid", 32'(key_valid), 0);
    check("rst_err", 32'(frame_err), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Plain make code
    v0 = n_valid; e0 = n_err;
    send_frame(8'h1C, 1'b0, 1'b1);
    check("t1_nvalid", 32'(n_valid - v0), 1);
    check("t1_nerr", 32'(n_err - e0), 0);
    check("t1_code", 32'(key_code), 32'h01C);
    check("t1_break", 32'(key_break), 0);

    // Break prefix alone emits nothing, then release of 1C
    v0 = n_valid;
    send_frame(8'hF0, 1'b0, 1'b1);
    check("t2_f0_nvalid", 32'(n_valid - v0), 0);
    check("t2_f0_hold", 32'(key_code), 32'h01C);
    send_frame(8'h1C, 1'b0, 1'b1);
    check("t2_nvalid", 32'(n_valid - v0), 1);
    check("t2_code", 32'(key_code), 32'h01C);
    check("t2_break", 32'(key_break), 1);

    // Extended release, then flags must be clear
    v0 = n_valid;
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    check("t3_prefix_nvalid", 32'(n_valid - v0), 0);
    send_frame(8'h74, 1'b0, 1'b1);
    check("t3_nvalid", 32'(n_valid - v0), 1);
    check("t3_code", 32'(key_code), 32'h174);
    check("t3_break", 32'(key_break), 1);
    send_frame(8'h1C, 1'b0, 1'b1);
    check("t3b_code", 32'(key_code), 32'h01C);
    check("t3b_break", 32'(key_break), 0);

    // Parity error, then recovery
    v0 = n_valid; e0 = n_err;
    send_frame(8'h1C, 1'b1, 1'b1);
    check("t4_nerr", 32'(n_err - e0), 1);
    check("t4_nvalid", 32'(n_valid - v0), 0);
    send_frame(8'h1C, 1'b0, 1'b1);
    check("t4b_nvalid", 32'(n_valid - v0), 1);
    check("t4b_code", 32'(key_code), 32'h01C);

    // Stop-bit error after an E0 prefix: ext must be cleared
    v0 = n_valid; e0 = n_err;
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'h33, 1'b0, 1'b0);
    check("t5_nerr", 32'(n_err - e0), 1);
    send_frame(8'h33, 1'b0, 1'b1);
    check("t5_code", 32'(key_code), 32'h033);

    // Glitch on ps2_clk with data low must not start a frame
    @(negedge clk);
    ps2_data = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (2) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (5) @(negedge clk);
    ps2_data = 1'b1;
    repeat (GAP) @(negedge clk);
    v0 = n_valid; e0 = n_err;
    send_frame(8'h5A, 1'b0, 1'b1);
    check("t6_code", 32'(key_code), 32'h05A);
    check("t6_nerr", 32'(n_err - e0), 0);

    // Timeout: start bit plus 5 data bits, then clock stays high
    v0 = n_valid; e0 = n_err;
    b29 = 8'h29;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(b29[i]);
    ps2_data = 1'b1;
    for (int i = 0; i < TOUT + 100 && n_err == e0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    $display("timeout: err=%0d delay=%0d cycles", n_err - e0, err_cyc - fall_cyc);
    check("t7_nerr", 32'(n_err - e0), 1);
    check("t7_window", 32'((err_cyc - fall_cyc >= TOUT) && (err_cyc - fall_cyc <= TOUT + FILT + 6)), 1);
    check("t7_nvalid", 32'(n_valid - v0), 0);
    repeat (GAP) @(negedge clk);
    send_frame(8'h29, 1'b0, 1'b1);
    check("t7b_code", 32'(key_code), 32'h029);

    // Reset mid-frame after an E0 prefix
    e0 = n_err;
    send_frame(8'hE0, 1'b0, 1'b1);
    b74 = 8'h74;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(b74[i]);
    ps2_data = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t8_rst_code", 32'(key_code), 32'h000);
    check("t8_rst_break", 32'(key_break), 0);
    check("t8_rst_valid", 32'(key_valid), 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (GAP) @(negedge clk);
    check("t8_nerr", 32'(n_err - e0), 0);
    $display("reset mid-frame: err=%0d code=%03h", n_err - e0, key_code);
    send_frame(8'h74, 1'b0, 1'b1);
    check("t8b_code", 32'(key_code), 32'h074);
    check("t8b_break", 32'(key_break), 0);

    check("pulse_overlap", 32'(overlap), 0);
    check("pulse_consec", 32'(consec), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_scan_rx.md
PS2_SCAN_RX -- requirements
Module: ps2_scan_rx

Interface
REQ-001 SHALL have parameter FILT_LEN, default 8, the number of consecutive equal synchronized samples of ps2_clk needed to accept a new level.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 100000, the number of clk cycles without a PS/2 falling edge, mid-frame, before the frame is aborted.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock (100 MHz).
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port ps2_clk, input, 1 bit: raw PS/2 clock, asynchronous; receive-only and never driven.
REQ-006 SHALL have port ps2_data, input, 1 bit: raw PS/2 data, asynchronous; receive-only and never driven.
REQ-007 SHALL have port key_code, output, 9 bits: {extended flag, scan byte} of the last decoded key.
REQ-008 SHALL have port key_break, output, 1 bit: 1 when the last decoded event was a release.
REQ-009 SHALL have port key_valid, output, 1 bit: a one-cycle pulse when key_code and key_break are updated.
REQ-010 SHALL have port frame_err, output, 1 bit: a one-cycle pulse on a parity, stop-bit or timeout error.

Function
REQ-011 SHALL pass ps2_clk and ps2_data through 2-flop synchronizers; the filtered ps2_clk SHALL change only after FILT_LEN consecutive equal samples.
REQ-012 SHALL detect a falling edge of the filtered ps2_clk and sample synchronized ps2_data in that cycle.
REQ-013 SHALL use frame FSM states IDLE, DATA, PARITY and STOP.
REQ-014 IDLE: on an edge with data 0 (start bit), SHALL go to DATA and clear the bit counter; on an edge with data 1, SHALL stay in IDLE with no error.
REQ-015 DATA: SHALL shift 8 bits LSB first; after the 8th bit (counter 7) SHALL go to PARITY.
REQ-016 PARITY: SHALL capture the bit and go to STOP; odd parity is required (8 data bits + parity bit contain an odd number of ones).
REQ-017 STOP: on the edge, SHALL return to IDLE; if parity is good and stop = 1, the byte is accepted, otherwise frame_err SHALL pulse and the byte is discarded.
REQ-018 In any state other than IDLE, a timeout counter SHALL run; it SHALL reset on every falling edge. When it reaches TIMEOUT_CYC-1, the FSM SHALL go to IDLE and frame_err SHALL pulse.
REQ-019 An accepted byte 8'hE0 SHALL set the ext flag and emit nothing.
REQ-020 An accepted byte 8'hF0 SHALL set the brk flag and emit nothing.
REQ-021 Any other accepted byte (including 8'hE1) SHALL, in the cycle after the stop edge, load key_code = {ext, byte} and key_break = brk, pulse key_valid for one cycle, and clear ext and brk.
REQ-022 Any frame error SHALL clear ext and brk in addition to pulsing frame_err.
REQ-023 key_code and key_break SHALL hold their values between key_valid pulses.
REQ-024 key_valid and frame_err SHALL never be asserted in the same cycle, and neither SHALL be asserted for two consecutive cycles.

Reset
REQ-025 On rst_n = 0, SHALL asynchronously set: FSM to IDLE; shift register, bit counter and timeout counter to 0; ext and brk to 0; key_code to 9'h000; key_break, key_valid and frame_err to 0; filtered ps2_clk and synchronizers to 1 (bus idle).
REQ-026 Reset mid-frame SHALL discard the partial frame with no frame_err pulse.
REQ-027 After reset release, decoding SHALL start only at the next start bit.

Structure
REQ-028 Shared package ps2_pkg SHALL hold: PS2_PREFIX_EXT = 8'hE0, PS2_PREFIX_BRK = 8'hF0, the frame state encoding, and the default FILT_LEN/TIMEOUT_CYC values.
REQ-029 SHALL contain one sub-module, ps2_sync_filter (synchronizers, glitch filter, falling-edge pulse output); the FSM, decode and output registers SHALL be in ps2_scan_rx.

Verification
REQ-030 Frame 0x1C (parity 0, stop 1) -> exactly one key_valid; key_code = 9'h01C, key_break = 0.
REQ-031 Frames F0, 1C -> exactly one key_valid, after the second frame; key_code = 9'h01C, key_break = 1; no pulse after F0.
REQ-032 Frames E0, F0, 74 -> one key_valid; key_code = 9'h174, key_break = 1; the next frame 1C gives 9'h01C, key_break = 0 (flags cleared).
REQ-033 Frame 0x1C with parity 1, then a good 0x1C -> frame_err pulse, no key_valid for the first frame; then key_valid with 9'h01C.
REQ-034 Start bit plus 5 data bits, then ps2_clk held high -> frame_err exactly TIMEOUT_CYC cycles after the last edge; a following good frame 0x29 gives key_code 9'h029.
REQ-035 Drive E0 then pulse rst_n low mid-frame during the next frame -> no frame_err, outputs at reset values; a following frame 0x74 gives 9'h074 (ext cleared by reset).
